// File: rtl/output_argmax_if.sv
// Bundle between the argmax unit and its surroundings:
// start/status handshake, output-RAM read port and the result.
interface output_argmax_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] digit;
    logic [DATA_WIDTH-1:0] max_val;

    modport master (
        output start,
        input  ram_addr,
        output ram_q,
        input  busy,
        input  done,
        input  valid,
        input  digit,
        input  max_val
    );

    modport slave (
        input  start,
        output ram_addr,
        input  ram_q,
        output busy,
        output done,
        output valid,
        output digit,
        output max_val
    );
endinterface

// File: rtl/output_argmax_unit.sv
// Classifier back end: sweeps the output RAM and reports the
// index and value of the largest unsigned entry.
module output_argmax_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_OUTPUTS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output_argmax_if.slave    io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(NUM_OUTPUTS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cmp_vld_q, cmp_vld_d;
    logic [ADDR_WIDTH-1:0] cmp_idx_q, cmp_idx_d;
    logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
    logic [ADDR_WIDTH-1:0] best_idx_q, best_idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] digit_q, digit_d;
    logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
    logic                  take;

    // RAM data lags the issued address by one cycle, so the
    // address copy in cmp_idx_q names the entry now on ram_q.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        take = cmp_vld_q &&
               ((cmp_idx_q == '0) || (io.ram_q > best_val_q));
        if (take) begin
            best_val_d = io.ram_q;
            best_idx_d = cmp_idx_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        digit_d   = digit_q;
        max_val_d = max_val_q;
        cmp_vld_d = (state_q == SCAN);
        cmp_idx_d = addr_q;
        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                if (io.start) begin
                    state_d = SCAN;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Last entry is compared on this edge; publish the
                // post-compare best rather than the stale register.
                state_d   = IDLE;
                addr_d    = '0;
                done_d    = 1'b1;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                digit_d   = best_idx_d;
                max_val_d = best_val_d;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            digit_q    <= '0;
            max_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_idx_q  <= cmp_idx_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            digit_q    <= digit_d;
            max_val_q  <= max_val_d;
        end
    end

    assign io.ram_addr = addr_q;
    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.valid    = valid_q;
    assign io.digit    = digit_q;
    assign io.max_val  = max_val_q;

endmodule

// File: doc/output_argmax_unit.md
# output_argmax_unit

Classifier back end that consumes the output-layer RAM. On `start` it sweeps the first `NUM_OUTPUTS` entries of the output RAM, compares each unsigned value, and reports the index of the largest (the predicted class) together with that value. It drives the RAM read address directly and accounts for the RAM's registered-address, one-cycle read latency; it never writes the RAM.

## Interface
- `DATA_WIDTH`, default 8: width of one RAM entry and of `max_val`.
- `ADDR_WIDTH`, default 4: RAM address width; also the width of `digit`.
- `NUM_OUTPUTS`, default 10: entries scanned, at addresses 0..NUM_OUTPUTS-1.
  - Legal range is 1 ≤ NUM_OUTPUTS ≤ 2**ADDR_WIDTH.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `ram_addr`  out  ADDR_WIDTH  read address to the output RAM.
- `ram_q`  in  DATA_WIDTH  RAM read data.
  - Equals the entry at the `ram_addr` sampled on the previous edge.
- `busy`  out  1  high from the edge after `start` is accepted until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `digit`/`max_val` updated on the same edge.
- `valid`  out  1  set with `done`, cleared when the next `start` is accepted or on reset.
- `digit`  out  ADDR_WIDTH  index of the maximum entry.
- `max_val`  out  DATA_WIDTH  value of the maximum entry.

## Operation
- Reset (`rst_n`=0, immediate, regardless of `clk`):
  - State goes to IDLE.
  - `ram_addr`, `busy`, `done`, `valid`, `digit`, `max_val` all go to 0.
  - Counters and working registers are cleared.
- States: IDLE, SCAN, DRAIN.
  - IDLE: `ram_addr`=0.
    - `start`=1 → SCAN; address counter cleared to 0; `valid` cleared; `busy` set.
  - SCAN: `ram_addr` = address counter, which increments each cycle.
    - After the cycle presenting address NUM_OUTPUTS-1 → DRAIN.
    - `ram_addr` is held at NUM_OUTPUTS-1 on the transition edge.
  - DRAIN: one cycle. Compares the last entry, then → IDLE.
    - On that transition edge: `done`=1, `valid`=1, `busy`=0; `digit` and `max_val` are loaded from the working best index/value.
- Compare pipeline:
  - A one-cycle-delayed copy of the issued address (`cmp_idx`) plus a delayed valid flag qualify `ram_q`.
  - For cmp_idx=0, best value/index load unconditionally.
  - Otherwise they update only when `ram_q` > best value (unsigned, strict).
  - Ties therefore resolve to the lowest index.
- `digit`/`max_val` hold their previous result throughout a scan. They change only on the `done` edge.
- `start` while SCAN or DRAIN is ignored. It is not queued.
- Reset mid-scan aborts the scan: no `done` pulse, and outputs return to their reset values.
- NUM_OUTPUTS=1: SCAN lasts one cycle; result is index 0.

## Timing
- Number edges from E0, the edge that samples `start`=1 in IDLE.
- SCAN occupies cycles after E0..E(N-1), with `ram_addr`=0..N-1 (N=NUM_OUTPUTS).
- Entry i is compared at edge E(i+2).
- DRAIN is the cycle after EN. `done`=1 and results are valid in the cycle after E(N+1).
  - Latency from the start edge to `done` high is N+1 cycles (11 for the defaults).
- `busy`=1 for exactly N+1 cycles.
- Back-to-back: `start`=1 in the `done` cycle is accepted, because the state is already IDLE. The new scan begins with no idle gap.
- `start` must be synchronous to `clk`. No input is registered before use other than by the FSM.

## Test plan
- **Basic scan:**
  - Stimulus: RAM[0..9] = 10,20,30,200,40,50,60,70,80,90; pulse `start`.
  - Required: `ram_addr` steps 0..9; `done` 11 cycles after the start edge; `digit`=3, `max_val`=200, `valid`=1; `busy` high exactly 11 cycles.
- **Tie and edges:**
  - RAM = 5,255,7,255,0,…,0 → `digit`=1, `max_val`=255.
  - RAM all 0 → `digit`=0, `max_val`=0.
  - Max only at index 9 (value 1, rest 0) → `digit`=9.
- **Start while busy:** assert `start` continuously through the scan. Required: exactly one `done` per 11-cycle scan, then an immediate back-to-back rescan with no idle cycle.
- **Result hold:**
  - First scan gives `digit`=3.
  - Rewrite RAM so index 6 is the max and restart.
  - Required: `digit` stays 3 and `valid`=0 during the scan; `digit` becomes 6 on the `done` edge.
- **Async reset mid-scan:**
  - Drop `rst_n` between edges at E5.
  - Required: all outputs are 0 immediately, without waiting for a clock edge; no `done` pulse.
  - After release, a new `start` produces the correct result.
- **Parameter corner:** `NUM_OUTPUTS`=1 and `NUM_OUTPUTS`=16 (full RAM). Required: `done` at 2 and 17 cycles respectively, with the correct argmax.
